traffic_light_xing: RTL and testbench
=====================================

TRAFFIC_LIGHT_XING -- requirements
Module: traffic_light_xing

Interface
REQ-001 SHALL provide parameter N_DIR, default 2, number of approach directions (legal 2..4).
REQ-002 SHALL provide parameter CNT_W, default 16, phase-timer width.
REQ-003 SHALL provide parameters G_TIME=1024, Y_TIME=512, AR_TIME=16, MIN_G=64, FLASH_HALF=32, all in cycles, each >=1 and < 2**CNT_W.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have: pass  input  N_DIR  per-direction request pulse, sampled at rising clk.
REQ-007 SHALL have: flash  input  1  level; high selects night flashing mode.
REQ-008 SHALL have: R, G, Y  output  N_DIR each  lamp drives per direction, registered.
REQ-009 SHALL have: cur_dir  output  2  index of the direction currently served.

Function
REQ-010 SHALL implement states GREEN, YELLOW, ALL_RED, FLASH plus a phase timer and a cur_dir register.
REQ-011 SHALL, for every direction d at every cycle outside FLASH, assert exactly one of R[d], G[d], Y[d]; only cur_dir may be non-red.
REQ-012 SHALL hold GREEN for G_TIME cycles, then YELLOW for Y_TIME, then ALL_RED (all R) for AR_TIME, then GREEN of the next direction.
REQ-013 SHALL choose the next direction as the first pending requester in round-robin order after cur_dir; with none pending, cur_dir+1 modulo N_DIR.
REQ-014 SHALL latch each pass[j] into a pending bit that is cleared when direction j enters GREEN.
REQ-015 SHALL, on pass[cur_dir] during GREEN, reload the green timer so GREEN lasts G_TIME further cycles.
REQ-016 SHALL, with any other direction pending during GREEN and elapsed green >= MIN_G, enter YELLOW on the next cycle; if elapsed < MIN_G, enter YELLOW on the cycle elapsed reaches MIN_G.
REQ-017 SHALL latch pass pulses arriving during YELLOW or ALL_RED, affecting only next-direction selection, never shortening those phases.
REQ-018 SHALL resolve simultaneous pass bits purely by REQ-013 ordering; pass[cur_dir] together with another bit: other wins, no reload.
REQ-019 SHALL, when flash is high, enter FLASH on the next cycle from any state: all R=0, G=0, Y toggling every FLASH_HALF cycles starting at 1.
REQ-020 SHALL ignore and clear pending bits in FLASH.
REQ-021 SHALL, on flash falling, go to ALL_RED for AR_TIME then GREEN of direction 0.
REQ-022 SHALL never let the timer wrap; timer saturates at 2**CNT_W-1.

Reset
REQ-023 SHALL, while rst is high at a rising clk, set state GREEN, cur_dir=0, timer=0, pending=0, G[0]=1, R[d]=1 for d!=0, all Y=0.
REQ-024 SHALL apply reset from any state mid-phase, including FLASH, with the first post-reset cycle counting as green cycle 1.
REQ-025 SHALL take flash precedence over the reset-released GREEN only from the cycle after rst falls.

Structure
REQ-026 SHALL place the state encoding and default timing constants in shared package traffic_light_pkg.
REQ-027 SHALL implement next-direction selection as sub-module tl_next_dir (inputs cur_dir, pending; output next index).
REQ-028 SHALL be fully synchronous, single clock domain, no latches.

Verification (N_DIR=2, defaults)
REQ-029 Reset then idle 8192 cycles -> G0 1024, Y0 512, all-red 16, G1 1024, ... repeating with period 3104 cycles.
REQ-030 pass[1] at green cycle 10 of dir 0 -> Y0 asserted at green cycle 65, dir 1 green after 512+16 cycles.
REQ-031 pass[0] at green cycle 900 of dir 0 -> G0 lasts until cycle 1924 total.
REQ-032 pass[1] during Y0 -> Y0 still 512 cycles, all-red 16, then G1; pending[1] cleared.
REQ-033 flash high at mid-G1 for 200 cycles -> Y all toggling every 32 cycles, R/G all 0; after fall, 16 all-red cycles then G0.
REQ-034 rst pulse during Y0 cycle 300 -> next cycle G0=1, R1=1, timer restarted, full 1024-cycle G0.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_pkg
// Shared definitions for the traffic_light_xing controller:
//   - tl_state_e : controller phase encoding (GREEN, YELLOW, ALL_RED, FLASH)
//   - DEF_*      : default timing constants, in clock cycles
//   - DIR_W      : width of a direction index (up to four approaches)
// No ports; imported by traffic_light_xing and tl_next_dir.
// -----------------------------------------------------------------------------
package traffic_light_pkg;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALL_RED = 2'd2,
        ST_FLASH   = 2'd3
    } tl_state_e;

    // Direction index width; covers the legal range of 2..4 approaches.
    localparam int unsigned DIR_W = 2;

    localparam int unsigned DEF_N_DIR      = 2;
    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_G_TIME     = 1024;
    localparam int unsigned DEF_Y_TIME     = 512;
    localparam int unsigned DEF_AR_TIME    = 16;
    localparam int unsigned DEF_MIN_G      = 64;
    localparam int unsigned DEF_FLASH_HALF = 32;

endpackage

// File: rtl/traffic_light_xing_next_dir.sv
// -----------------------------------------------------------------------------
// tl_next_dir
// Round-robin selection of the next direction to serve.
// Scans cur_dir+1, cur_dir+2, ... (modulo N_DIR) and returns the first
// direction with its pending bit set; cur_dir itself is considered last.
// With nothing pending the result is cur_dir+1 modulo N_DIR.
// Ports:
//   cur_dir  in  DIR_W  direction currently served
//   pending  in  N_DIR  pending request bits
//   next_dir out DIR_W  selected next direction
// -----------------------------------------------------------------------------
module tl_next_dir
    import traffic_light_pkg::*;
#(
    parameter int unsigned N_DIR = DEF_N_DIR
) (
    input  logic [DIR_W-1:0] cur_dir,
    input  logic [N_DIR-1:0] pending,
    output logic [DIR_W-1:0] next_dir
);

    localparam int unsigned SUM_W = DIR_W + 2;

    // (base + step) modulo N_DIR; base < N_DIR and step <= N_DIR, so one
    // conditional subtract is enough.
    function automatic logic [DIR_W-1:0] wrap_add(input logic [DIR_W-1:0] base,
                                                  input int step);
        logic [SUM_W-1:0] sum;
        sum = {2'b00, base} + SUM_W'(step);
        if (sum >= SUM_W'(N_DIR)) begin
            sum = sum - SUM_W'(N_DIR);
        end
        return sum[DIR_W-1:0];
    endfunction

    logic [DIR_W-1:0] cand;
    logic [N_DIR-1:0] cand_mask;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so
        // no path leaves it unassigned and no latch is inferred.
        next_dir  = wrap_add(cur_dir, 1);
        cand      = '0;
        cand_mask = '0;
        // Scan farthest-first so the nearest pending requester is written last
        // and therefore wins.
        for (int k = int'(N_DIR); k >= 1; k--) begin
            cand      = wrap_add(cur_dir, k);
            cand_mask = N_DIR'(1) << cand;
            if (|(pending & cand_mask)) begin
                next_dir = cand;
            end
        end
    end

endmodule

// File: rtl/traffic_light_xing.sv
// -----------------------------------------------------------------------------
// traffic_light_xing
// Multi-approach intersection controller. Serves one direction at a time with
// GREEN -> YELLOW -> ALL_RED, then picks the next direction round-robin among
// pending requesters. A flash input overrides everything with all-yellow
// blinking; leaving flash goes through ALL_RED to direction 0.
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset
//   pass     in   N_DIR  per-direction request pulses
//   flash    in   1      level, selects night flashing mode
//   R, G, Y  out  N_DIR  registered lamp drives per direction
//   cur_dir  out  2      direction currently served
// -----------------------------------------------------------------------------
module traffic_light_xing
    import traffic_light_pkg::*;
#(
    parameter int unsigned N_DIR      = DEF_N_DIR,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned G_TIME     = DEF_G_TIME,
    parameter int unsigned Y_TIME     = DEF_Y_TIME,
    parameter int unsigned AR_TIME    = DEF_AR_TIME,
    parameter int unsigned MIN_G      = DEF_MIN_G,
    parameter int unsigned FLASH_HALF = DEF_FLASH_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DIR-1:0] pass,
    input  logic             flash,
    output logic [N_DIR-1:0] R,
    output logic [N_DIR-1:0] G,
    output logic [N_DIR-1:0] Y,
    output logic [1:0]       cur_dir
);

    // The phase timer holds (cycles spent in the phase - 1), so a phase of
    // length T ends on the cycle where the timer equals T-1.
    localparam logic [CNT_W-1:0] G_LAST     = CNT_W'(G_TIME - 1);
    localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(Y_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(AR_TIME - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] MIN_G_LAST = CNT_W'(MIN_G - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    tl_state_e        state_q, state_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
    // Green time since entering GREEN; unlike the phase timer it is not
    // restarted by a same-direction reload.
    logic [CNT_W-1:0] g_elapsed_q, g_elapsed_d, g_elapsed_inc;
    logic [N_DIR-1:0] pending_q, pending_d;
    logic             flash_y_q, flash_y_d;
    // Set while the ALL_RED that follows FLASH is running; forces direction 0.
    logic             post_flash_q, post_flash_d;
    logic [N_DIR-1:0] r_q, r_d, g_q, g_d, y_q, y_d;

    logic [N_DIR-1:0] req;
    logic [N_DIR-1:0] cur_mask;
    logic [N_DIR-1:0] next_mask;
    logic [N_DIR-1:0] lamp_mask;
    logic             own_req;
    logic             other_req;
    logic [DIR_W-1:0] rr_dir;

    // Requests seen this cycle: latched ones plus pulses arriving now.
    assign req       = pending_q | pass;
    assign cur_mask  = N_DIR'(1) << dir_q;
    assign own_req   = |(pass & cur_mask);
    assign other_req = |(req & ~cur_mask);

    tl_next_dir #(
        .N_DIR (N_DIR)
    ) u_next_dir (
        .cur_dir  (dir_q),
        .pending  (req),
        .next_dir (rr_dir)
    );

    always_comb begin
        timer_inc     = (&timer_q)     ? timer_q     : timer_q + CNT_ONE;
        g_elapsed_inc = (&g_elapsed_q) ? g_elapsed_q : g_elapsed_q + CNT_ONE;

        state_d      = state_q;
        dir_d        = dir_q;
        timer_d      = timer_inc;
        g_elapsed_d  = g_elapsed_inc;
        pending_d    = req;
        flash_y_d    = flash_y_q;
        post_flash_d = post_flash_q;
        next_mask    = '0;

        if (flash) begin
            // Flash overrides every phase; requests are dropped meanwhile.
            pending_d = '0;
            if (state_q != ST_FLASH) begin
                state_d   = ST_FLASH;
                timer_d   = '0;
                flash_y_d = 1'b1;
            end else if (timer_q == FLASH_LAST) begin
                timer_d   = '0;
                flash_y_d = ~flash_y_q;
            end
        end else begin
            unique case (state_q)
                ST_GREEN: begin
                    // A pulse from the served direction is consumed by the
                    // reload below and is never left pending.
                    pending_d = req & ~cur_mask;
                    if (other_req && (g_elapsed_q >= MIN_G_LAST)) begin
                        state_d = ST_YELLOW;
                        timer_d = '0;
                    end else if (own_req && !other_req) begin
                        timer_d = '0;
                    end else if (timer_q == G_LAST) begin
                        state_d = ST_YELLOW;
                        timer_d = '0;
                    end
                end
                ST_YELLOW: begin
                    if (timer_q == Y_LAST) begin
                        state_d = ST_ALL_RED;
                        timer_d = '0;
                    end
                end
                ST_ALL_RED: begin
                    if (timer_q == AR_LAST) begin
                        state_d      = ST_GREEN;
                        timer_d      = '0;
                        g_elapsed_d  = '0;
                        dir_d        = post_flash_q ? '0 : rr_dir;
                        post_flash_d = 1'b0;
                        next_mask    = N_DIR'(1) << dir_d;
                        pending_d    = req & ~next_mask;
                    end
                end
                ST_FLASH: begin
                    state_d      = ST_ALL_RED;
                    timer_d      = '0;
                    post_flash_d = 1'b1;
                    pending_d    = '0;
                end
                default: begin
                    state_d = ST_ALL_RED;
                    timer_d = '0;
                end
            endcase
        end

        // Lamps are decoded from the next state so the registered outputs
        // line up with the phase they describe.
        lamp_mask = N_DIR'(1) << dir_d;
        r_d       = '0;
        g_d       = '0;
        y_d       = '0;
        unique case (state_d)
            ST_GREEN: begin
                g_d = lamp_mask;
                r_d = ~lamp_mask;
            end
            ST_YELLOW: begin
                y_d = lamp_mask;
                r_d = ~lamp_mask;
            end
            ST_ALL_RED: begin
                r_d = '1;
            end
            ST_FLASH: begin
                y_d = {N_DIR{flash_y_d}};
            end
            default: begin
                r_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= ST_GREEN;
            dir_q        <= '0;
            timer_q      <= '0;
            g_elapsed_q  <= '0;
            pending_q    <= '0;
            flash_y_q    <= 1'b0;
            post_flash_q <= 1'b0;
            g_q          <= N_DIR'(1);
            r_q          <= ~(N_DIR'(1));
            y_q          <= '0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            timer_q      <= timer_d;
            g_elapsed_q  <= g_elapsed_d;
            pending_q    <= pending_d;
            flash_y_q    <= flash_y_d;
            post_flash_q <= post_flash_d;
            g_q          <= g_d;
            r_q          <= r_d;
            y_q          <= y_d;
        end
    end

    assign R       = r_q;
    assign G       = g_q;
    assign Y       = y_q;
    assign cur_dir = dir_q;

endmodule

// File: tb/tb_traffic_light_xing.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_xing
// Drives traffic_light_xing (two approaches, default timing) with directed
// scenarios and random traffic. A reference model tracks phases as absolute
// cycle deadlines; a negedge process compares every cycle, and literal
// expectations at hand-derived cycles pin the model.
// -----------------------------------------------------------------------------
module tb_traffic_light_xing;

    localparam int N     = 2;
    localparam int G_T   = 1024;
    localparam int Y_T   = 512;
    localparam int AR_T  = 16;
    localparam int MIN_G = 64;
    localparam int FH    = 32;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         flash = 1'b0;
    logic [N-1:0] pass  = '0;
    logic [N-1:0] R, G, Y;
    logic [1:0]   cur_dir;

    traffic_light_xing #(
        .N_DIR      (N),
        .CNT_W      (16),
        .G_TIME     (G_T),
        .Y_TIME     (Y_T),
        .AR_TIME    (AR_T),
        .MIN_G      (MIN_G),
        .FLASH_HALF (FH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pass    (pass),
        .flash   (flash),
        .R       (R),
        .G       (G),
        .Y       (Y),
        .cur_dir (cur_dir)
    );

    always #5 clk = ~clk;

    int     n_total = 0;
    int     n_bad   = 0;
    longint now     = 0;   // index of the cycle currently on the outputs
    bit     chk_en  = 1'b0;

    // ---------------- reference model ----------------
    typedef enum int {P_GREEN, P_YELLOW, P_ALL_RED, P_FLASH} phase_t;

    phase_t       m_phase = P_GREEN;
    int           m_dir   = 0;
    logic [N-1:0] m_pend  = '0;
    longint       m_green_start = 0;
    longint       m_green_last  = 0;
    longint       m_phase_last  = 0;
    longint       m_flash_start = 0;
    bit           m_force0 = 1'b0;

    function automatic int pick_next();
        int cand;
        for (int k = 1; k <= N; k++) begin
            cand = (m_dir + k) % N;
            if (((m_pend >> cand) & 1) != 0) return cand;
        end
        return (m_dir + 1) % N;
    endfunction

    // Advance the model across the clock edge that ends cycle 'now'.
    task automatic model_edge(input logic r, input logic f, input logic [N-1:0] p);
        logic [N-1:0] oh;
        longint       elapsed;
        bit           others, own;
        int           nd;
        oh = N'(1) << m_dir;
        if (r) begin
            m_phase = P_GREEN; m_dir = 0; m_pend = '0; m_force0 = 1'b0;
            m_green_start = now + 1; m_green_last = now + G_T;
        end else if (f) begin
            if (m_phase != P_FLASH) begin
                m_phase = P_FLASH; m_flash_start = now + 1;
            end
            m_pend = '0;
        end else begin
            case (m_phase)
                P_FLASH: begin
                    m_phase = P_ALL_RED; m_phase_last = now + AR_T;
                    m_force0 = 1'b1; m_pend = '0;
                end
                P_GREEN: begin
                    elapsed = now - m_green_start + 1;
                    others  = |((m_pend | p) & ~oh);
                    own     = |(p & oh);
                    m_pend  = (m_pend | p) & ~oh;
                    if (others && elapsed >= MIN_G) begin
                        m_phase = P_YELLOW; m_phase_last = now + Y_T;
                    end else if (!others && own) begin
                        m_green_last = now + G_T;
                    end else if (now >= m_green_last) begin
                        m_phase = P_YELLOW; m_phase_last = now + Y_T;
                    end
                end
                P_YELLOW: begin
                    m_pend = m_pend | p;
                    if (now == m_phase_last) begin
                        m_phase = P_ALL_RED; m_phase_last = now + AR_T;
                    end
                end
                default: begin
                    m_pend = m_pend | p;
                    if (now == m_phase_last) begin
                        nd = m_force0 ? 0 : pick_next();
                        m_dir = nd;
                        m_pend = m_pend & ~(N'(1) << nd);
                        m_phase = P_GREEN; m_force0 = 1'b0;
                        m_green_start = now + 1; m_green_last = now + G_T;
                    end
                end
            endcase
        end
        now++;
    endtask

    function automatic logic [31:0] model_out();
        logic [N-1:0] er, eg, ey, oh;
        er = '0; eg = '0; ey = '0;
        oh = N'(1) << m_dir;
        case (m_phase)
            P_GREEN:   begin eg = oh; er = ~oh; end
            P_YELLOW:  begin ey = oh; er = ~oh; end
            P_ALL_RED: er = '1;
            default:   if (((now - m_flash_start) / FH) % 2 == 0) ey = '1;
        endcase
        return 32'({er, eg, ey, 2'(m_dir)});
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, got, exp, now);
        end
    endtask

    task automatic pin(input string name, input logic [N-1:0] er, input logic [N-1:0] eg,
                       input logic [N-1:0] ey, input logic [1:0] ed);
        check(name, 32'({R, G, Y, cur_dir}), 32'({er, eg, ey, ed}));
    endtask

    always @(negedge clk) begin
        if (chk_en) check("lamps", 32'({R, G, Y, cur_dir}), model_out());
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic f, input logic [N-1:0] p);
        rst = r; flash = f; pass = p;
        @(posedge clk);
        model_edge(r, f, p);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    int           flash_left;
    logic [N-1:0] rp;
    logic         rr;

    initial begin
        // Reset and idle cycling over 8192 cycles.
        step(1'b1, 1'b0, '0);
        chk_en = 1'b1;
        pin("reset_state",  2'b10, 2'b01, 2'b00, 2'd0);
        idle(1023); pin("g0_last",    2'b10, 2'b01, 2'b00, 2'd0);
        idle(1);    pin("y0_first",   2'b10, 2'b00, 2'b01, 2'd0);
        idle(511);  pin("y0_last",    2'b10, 2'b00, 2'b01, 2'd0);
        idle(1);    pin("ar_first",   2'b11, 2'b00, 2'b00, 2'd0);
        idle(15);   pin("ar_last",    2'b11, 2'b00, 2'b00, 2'd0);
        idle(1);    pin("g1_first",   2'b01, 2'b10, 2'b00, 2'd1);
        idle(1551); pin("period_ar",  2'b11, 2'b00, 2'b00, 2'd1);
        idle(1);    pin("period_g0",  2'b10, 2'b01, 2'b00, 2'd0);
        idle(8192 - 3105);

        // Request from dir 1 early in green: yellow once MIN_G is reached.
        step(1'b1, 1'b0, '0);
        idle(9);
        step(1'b0, 1'b0, 2'b10);
        idle(53);   pin("ming_g64",   2'b10, 2'b01, 2'b00, 2'd0);
        idle(1);    pin("ming_y65",   2'b10, 2'b00, 2'b01, 2'd0);
        idle(528);  pin("ming_g1",    2'b01, 2'b10, 2'b00, 2'd1);

        // Own-direction reload at green cycle 900, then request during yellow.
        step(1'b1, 1'b0, '0);
        idle(899);
        step(1'b0, 1'b0, 2'b01);
        idle(1023); pin("reload_g",   2'b10, 2'b01, 2'b00, 2'd0);
        idle(1);    pin("reload_y",   2'b10, 2'b00, 2'b01, 2'd0);
        step(1'b0, 1'b0, 2'b10);
        idle(510);  pin("ypass_y",    2'b10, 2'b00, 2'b01, 2'd0);
        idle(1);    pin("ypass_ar",   2'b11, 2'b00, 2'b00, 2'd0);
        idle(16);   pin("ypass_g1",   2'b01, 2'b10, 2'b00, 2'd1);
        idle(2575); pin("clear_g0",   2'b10, 2'b01, 2'b00, 2'd0);
        idle(1);    pin("clear_y0",   2'b10, 2'b00, 2'b01, 2'd0);

        // Flash for 200 cycles in the middle of G1.
        step(1'b1, 1'b0, '0);
        idle(1999); pin("pre_flash",  2'b01, 2'b10, 2'b00, 2'd1);
        step(1'b0, 1'b1, '0);
        pin("flash_1",    2'b00, 2'b00, 2'b11, 2'd1);
        repeat (31) step(1'b0, 1'b1, '0);
        pin("flash_32",   2'b00, 2'b00, 2'b11, 2'd1);
        step(1'b0, 1'b1, '0);
        pin("flash_33",   2'b00, 2'b00, 2'b00, 2'd1);
        repeat (167) step(1'b0, 1'b1, '0);
        pin("flash_200",  2'b00, 2'b00, 2'b11, 2'd1);
        idle(1);    pin("unflash_ar", 2'b11, 2'b00, 2'b00, 2'd1);
        idle(15);   pin("unflash_ar16", 2'b11, 2'b00, 2'b00, 2'd1);
        idle(1);    pin("unflash_g0", 2'b10, 2'b01, 2'b00, 2'd0);

        // Reset in the middle of yellow.
        step(1'b1, 1'b0, '0);
        idle(1323); pin("y0_c300",    2'b10, 2'b00, 2'b01, 2'd0);
        step(1'b1, 1'b0, '0);
        pin("rst_mid_y",  2'b10, 2'b01, 2'b00, 2'd0);
        idle(1023); pin("rst_g_full", 2'b10, 2'b01, 2'b00, 2'd0);
        idle(1);    pin("rst_y_after", 2'b10, 2'b00, 2'b01, 2'd0);

        // Reset wins over flash on the same edge; flash takes over afterwards.
        step(1'b1, 1'b1, '0);
        pin("rst_over_flash", 2'b10, 2'b01, 2'b00, 2'd0);
        step(1'b0, 1'b1, '0);
        pin("flash_after_rst", 2'b00, 2'b00, 2'b11, 2'd0);
        idle(1);    pin("flash_exit", 2'b11, 2'b00, 2'b00, 2'd0);

        // Simultaneous requests: the other direction wins, no reload.
        step(1'b1, 1'b0, '0);
        idle(99);
        step(1'b0, 1'b0, 2'b11);
        pin("both_y",     2'b10, 2'b00, 2'b01, 2'd0);
        idle(528);  pin("both_g1",    2'b01, 2'b10, 2'b00, 2'd1);

        // Random traffic, flash windows and occasional resets.
        flash_left = 0;
        for (int i = 0; i < 25000; i++) begin
            if (flash_left > 0) flash_left--;
            else if ($urandom_range(0, 3999) == 0) flash_left = $urandom_range(50, 300);
            rp = '0;
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(0, 299) == 0) rp = rp | (N'(1) << j);
            end
            rr = ($urandom_range(0, 7999) == 0);
            step(rr, flash_left > 0, rp);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
